// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the load/store controller: widths, RV32I
// load/store funct3 encodings, FSM states and the request legality check.
package lsu_mem_ctrl_pkg;

   localparam int CPU_WIDTH           = 32;
   localparam int DATA_MEM_ADDR_WIDTH = 8;

   typedef enum logic [2:0] {
      LSU_B  = 3'b000,
      LSU_H  = 3'b001,
      LSU_W  = 3'b010,
      LSU_BU = 3'b100,
      LSU_HU = 3'b101
   } lsu_funct3_e;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ST_WR,
      RMW_RD,
      RMW_WR,
      RESP
   } lsu_state_e;

   // Unsigned variants exist only for loads; every other funct3 is illegal.
   function automatic logic lsu_req_err(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] off);
      logic err;
      case (funct3)
         LSU_B:   err = 1'b0;
         LSU_H:   err = off[0];
         LSU_W:   err = |off;
         LSU_BU:  err = we;
         LSU_HU:  err = we | off[0];
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response and memory-side bus of the load/store controller.
// slave is the controller's view; master is the core plus data memory.
interface lsu_mem_ctrl_if;
   import lsu_mem_ctrl_pkg::*;

   logic                 lsu_req;
   logic                 lsu_ready;
   logic                 lsu_we;
   logic [2:0]           lsu_funct3;
   logic [CPU_WIDTH-1:0] lsu_addr;
   logic [CPU_WIDTH-1:0] lsu_wdata;
   logic                 lsu_done;
   logic                 lsu_err;
   logic [CPU_WIDTH-1:0] lsu_rdata;
   logic                 mem_wen;
   logic                 mem_ren;
   logic [CPU_WIDTH-1:0] mem_addr;
   logic [CPU_WIDTH-1:0] mem_wdata;
   logic [CPU_WIDTH-1:0] mem_rdata;

   modport slave (
      input  lsu_req, lsu_we, lsu_funct3, lsu_addr, lsu_wdata, mem_rdata,
      output lsu_ready, lsu_done, lsu_err, lsu_rdata,
             mem_wen, mem_ren, mem_addr, mem_wdata
   );

   modport master (
      output lsu_req, lsu_we, lsu_funct3, lsu_addr, lsu_wdata, mem_rdata,
      input  lsu_ready, lsu_done, lsu_err, lsu_rdata,
             mem_wen, mem_ren, mem_addr, mem_wdata
   );

endinterface

// File: rtl/lsu_mem_ctrl_align.sv
// Little-endian lane logic: load extract/extend and sub-word store merge.
// Purely combinational.
module lsu_align
   import lsu_mem_ctrl_pkg::*;
(
   input  logic [CPU_WIDTH-1:0] word,
   input  logic [1:0]           off,
   input  logic [2:0]           funct3,
   output logic [CPU_WIDTH-1:0] load_data,
   input  logic [CPU_WIDTH-1:0] old_word,
   input  logic [CPU_WIDTH-1:0] wdata,
   output logic [CPU_WIDTH-1:0] new_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{off, 3'b000} +: 8];
      half_sel = word[{off[1], 4'b0000} +: 16];
      case (funct3)
         LSU_B:   load_data = {{(CPU_WIDTH-8){byte_sel[7]}}, byte_sel};
         LSU_H:   load_data = {{(CPU_WIDTH-16){half_sel[15]}}, half_sel};
         LSU_BU:  load_data = {{(CPU_WIDTH-8){1'b0}}, byte_sel};
         LSU_HU:  load_data = {{(CPU_WIDTH-16){1'b0}}, half_sel};
         default: load_data = word;
      endcase
   end

   always_comb begin
      new_word = old_word;
      case (funct3)
         LSU_B:   new_word[{off, 3'b000} +: 8]     = wdata[7:0];
         LSU_H:   new_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
         default: new_word = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of the word-wide data memory: one request at
// a time, sub-word stores by read-modify-write, loads extracted and extended.
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
(
   input logic           clk,
   input logic           rst_n,
   lsu_mem_ctrl_if.slave bus
);

   lsu_state_e           state, state_nxt;
   logic [CPU_WIDTH-1:0] addr_q, wdata_q, merge_q, rdata_q;
   logic [2:0]           funct3_q;
   logic                 we_q, err_q;
   logic                 accept, req_err;
   logic [CPU_WIDTH-1:0] load_data, store_word, word_addr;

   assign accept    = bus.lsu_req && (state == IDLE);
   assign req_err   = lsu_req_err(bus.lsu_we, bus.lsu_funct3, bus.lsu_addr[1:0]);
   assign word_addr = {addr_q[CPU_WIDTH-1:2], 2'b00};
   assign bus.lsu_rdata = rdata_q;

   lsu_align u_align (
      .word      (bus.mem_rdata),
      .off       (addr_q[1:0]),
      .funct3    (funct3_q),
      .load_data (load_data),
      .old_word  (merge_q),
      .wdata     (wdata_q),
      .new_word  (store_word)
   );

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         merge_q  <= '0;
         rdata_q  <= '0;
      end else begin
         if (accept) begin
            addr_q   <= bus.lsu_addr;
            wdata_q  <= bus.lsu_wdata;
            funct3_q <= bus.lsu_funct3;
            we_q     <= bus.lsu_we;
            err_q    <= req_err;
         end
         if (state == RMW_RD) merge_q <= bus.mem_rdata;
         if (state == LOAD)   rdata_q <= load_data;
      end
   end

   // Memory strobes and address are pure state decodes, so an async reset
   // drops them immediately and an interrupted RMW never writes.
   always_comb begin
      // NOTE: every output gets a default before the case; a path that left
      // one unassigned would infer a latch.
      state_nxt     = state;
      bus.lsu_ready = 1'b0;
      bus.lsu_done  = 1'b0;
      bus.lsu_err   = 1'b0;
      bus.mem_ren   = 1'b0;
      bus.mem_wen   = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      case (state)
         IDLE: begin
            bus.lsu_ready = 1'b1;
            if (bus.lsu_req) begin
               if (req_err)                       state_nxt = RESP;
               else if (!bus.lsu_we)              state_nxt = LOAD;
               else if (bus.lsu_funct3 == LSU_W)  state_nxt = ST_WR;
               else                               state_nxt = RMW_RD;
            end
         end
         LOAD: begin
            bus.mem_ren  = 1'b1;
            bus.mem_addr = word_addr;
            state_nxt    = RESP;
         end
         ST_WR: begin
            bus.mem_wen   = 1'b1;
            bus.mem_addr  = word_addr;
            bus.mem_wdata = wdata_q;
            state_nxt     = RESP;
         end
         RMW_RD: begin
            bus.mem_ren  = 1'b1;
            bus.mem_addr = word_addr;
            state_nxt    = RMW_WR;
         end
         RMW_WR: begin
            bus.mem_wen   = 1'b1;
            bus.mem_addr  = word_addr;
            bus.mem_wdata = store_word;
            state_nxt     = RESP;
         end
         RESP: begin
            bus.lsu_done = 1'b1;
            bus.lsu_err  = err_q;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // we_q is kept for visibility of the accepted request; decode uses funct3.
   logic unused_we;
   assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural data memory, ending in a
// back-to-back run checked against a reference memory and a mid-RMW reset.
module tb_lsu_mem_ctrl;
   import lsu_mem_ctrl_pkg::*;

   localparam int DEPTH = 2 ** DATA_MEM_ADDR_WIDTH;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lsu_mem_ctrl_if bus ();

   lsu_mem_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   logic        poke_en = 1'b0;
   logic [DATA_MEM_ADDR_WIDTH-1:0] poke_idx = '0;
   logic [31:0] poke_val = '0;
   int          wr_count = 0;
   int          accept_count = 0;
   logic        both_seen = 1'b0;

   assign bus.mem_rdata = mem[bus.mem_addr[DATA_MEM_ADDR_WIDTH+1:2]];

   always @(posedge clk) begin
      if (poke_en) mem[poke_idx] <= poke_val;
      else if (bus.mem_wen) mem[bus.mem_addr[DATA_MEM_ADDR_WIDTH+1:2]] <= bus.mem_wdata;
      if (bus.mem_wen) wr_count <= wr_count + 1;
      if (bus.mem_ren && bus.mem_wen) both_seen <= 1'b1;
      if (bus.lsu_req && bus.lsu_ready) accept_count <= accept_count + 1;
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_b(input string tag, input logic obs, input logic exp);
      check(tag, {31'b0, obs}, {31'b0, exp});
   endtask

   // Independent reference model of the load/store semantics.
   function automatic logic m_err(input logic we, input logic [2:0] f3, input logic [1:0] lo);
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
      if (we && f3[2]) return 1'b1;
      if ((f3 == 3'd1 || f3 == 3'd5) && lo[0]) return 1'b1;
      if (f3 == 3'd2 && lo != 2'd0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] word, input logic [2:0] f3,
                                          input logic [1:0] lo);
      logic [31:0] s;
      s = word >> {lo, 3'b000};
      case (f3)
         3'd0:    return {{24{s[7]}}, s[7:0]};
         3'd1:    return {{16{s[15]}}, s[15:0]};
         3'd4:    return {24'h0, s[7:0]};
         3'd5:    return {16'h0, s[15:0]};
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] m_store(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [2:0] f3, input logic [1:0] lo);
      logic [31:0] mask;
      mask = (f3 == 3'd0) ? 32'h0000_00FF : (f3 == 3'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      mask = mask << {lo, 3'b000};
      return (old & ~mask) | ((wd << {lo, 3'b000}) & mask);
   endfunction

   task automatic poke(input int idx, input logic [31:0] val);
      @(negedge clk);
      poke_idx = idx[DATA_MEM_ADDR_WIDTH-1:0];
      poke_val = val;
      poke_en  = 1'b1;
      ref_mem[idx] = val;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   // Observations of the last transaction; bit n of a mask = strobe seen in cycle T+n.
   int          lat;
   logic [7:0]  ren_mask, wen_mask;
   logic [31:0] wr_word, acc_addr, got_rdata;
   logic        got_err;

   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic hold);
      ren_mask = '0;
      wen_mask = '0;
      wr_word  = '0;
      acc_addr = '0;
      @(negedge clk);
      check_b("idle_ready", bus.lsu_ready, 1'b1);
      check_b("idle_done", bus.lsu_done, 1'b0);
      bus.lsu_req    = 1'b1;
      bus.lsu_we     = we;
      bus.lsu_funct3 = f3;
      bus.lsu_addr   = addr;
      bus.lsu_wdata  = wdata;
      @(negedge clk);
      if (!hold) bus.lsu_req = 1'b0;
      lat = 1;
      while (1) begin
         if (bus.mem_ren) begin ren_mask[lat] = 1'b1; acc_addr = bus.mem_addr; end
         if (bus.mem_wen) begin
            wen_mask[lat] = 1'b1;
            wr_word  = bus.mem_wdata;
            acc_addr = bus.mem_addr;
         end
         if (bus.lsu_done || lat >= 6) break;
         check_b("busy_ready", bus.lsu_ready, 1'b0);
         @(negedge clk);
         lat++;
      end
      got_err   = bus.lsu_err;
      got_rdata = bus.lsu_rdata;
   endtask

   task automatic expect_txn(input string tag, input int e_lat, input logic e_err,
                             input logic [31:0] e_rdata, input logic [7:0] e_ren,
                             input logic [7:0] e_wen, input logic [31:0] e_addr);
      check({tag, "_lat"}, lat, e_lat);
      check_b({tag, "_err"}, got_err, e_err);
      check({tag, "_rdata"}, got_rdata, e_rdata);
      check({tag, "_ren"}, {24'h0, ren_mask}, {24'h0, e_ren});
      check({tag, "_wen"}, {24'h0, wen_mask}, {24'h0, e_wen});
      check({tag, "_addr"}, acc_addr, e_addr);
   endtask

   function automatic logic [2:0] pick_f3(input int r);
      case (r)
         0: return 3'd0;
         1: return 3'd1;
         2: return 3'd2;
         3: return 3'd4;
         4: return 3'd5;
         5: return 3'd2;
         default: return 3'd3;
      endcase
   endfunction

   initial begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr, wdata, e_rdata, e_addr;
      logic        e_err;
      int          e_lat, acc0, wc0, idx;
      logic [7:0]  e_ren, e_wen;

      bus.lsu_req    = 1'b0;
      bus.lsu_we     = 1'b0;
      bus.lsu_funct3 = 3'd0;
      bus.lsu_addr   = '0;
      bus.lsu_wdata  = '0;

      repeat (2) @(negedge clk);
      check_b("rst_ready", bus.lsu_ready, 1'b1);
      check_b("rst_done", bus.lsu_done, 1'b0);
      check_b("rst_err", bus.lsu_err, 1'b0);
      check_b("rst_ren", bus.mem_ren, 1'b0);
      check_b("rst_wen", bus.mem_wen, 1'b0);
      check("rst_rdata", bus.lsu_rdata, 32'h0);
      check("rst_maddr", bus.mem_addr, 32'h0);

      poke(4, 32'h8899_AABB);
      poke(8, 32'h1122_3344);
      poke(20, 32'h0102_0304);
      for (int i = 16; i < 20; i++) poke(i, $urandom);
      @(negedge clk);
      rst_n = 1'b1;

      // Loads from 0x10 holding 0x8899AABB.
      run_req(1'b0, 3'd0, 32'h11, 32'h0, 1'b0);
      expect_txn("lb", 2, 1'b0, 32'hFFFF_FFAA, 8'h02, 8'h00, 32'h10);
      run_req(1'b0, 3'd4, 32'h13, 32'h0, 1'b0);
      expect_txn("lbu", 2, 1'b0, 32'h0000_0088, 8'h02, 8'h00, 32'h10);
      run_req(1'b0, 3'd1, 32'h12, 32'h0, 1'b0);
      expect_txn("lh", 2, 1'b0, 32'hFFFF_8899, 8'h02, 8'h00, 32'h10);
      run_req(1'b0, 3'd5, 32'h10, 32'h0, 1'b0);
      expect_txn("lhu", 2, 1'b0, 32'h0000_AABB, 8'h02, 8'h00, 32'h10);

      // Sub-word stores go through read-modify-write.
      run_req(1'b1, 3'd0, 32'h21, 32'h0000_00EE, 1'b0);
      expect_txn("sb", 3, 1'b0, 32'h0000_AABB, 8'h02, 8'h04, 32'h20);
      check("sb_wdata", wr_word, 32'h1122_EE44);
      run_req(1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
      expect_txn("lw_sb", 2, 1'b0, 32'h1122_EE44, 8'h02, 8'h00, 32'h20);

      run_req(1'b1, 3'd2, 32'h30, 32'hDEAD_BEEF, 1'b0);
      expect_txn("sw", 2, 1'b0, 32'h1122_EE44, 8'h00, 8'h02, 32'h30);
      check("sw_wdata", wr_word, 32'hDEAD_BEEF);
      run_req(1'b0, 3'd2, 32'h30, 32'h0, 1'b0);
      expect_txn("lw_sw", 2, 1'b0, 32'hDEAD_BEEF, 8'h02, 8'h00, 32'h30);

      // Error paths: no memory access, done at T+1, rdata held.
      run_req(1'b0, 3'd1, 32'h31, 32'h0, 1'b0);
      expect_txn("lh_mis", 1, 1'b1, 32'hDEAD_BEEF, 8'h00, 8'h00, 32'h0);
      run_req(1'b0, 3'd3, 32'h10, 32'h0, 1'b0);
      expect_txn("f3_011", 1, 1'b1, 32'hDEAD_BEEF, 8'h00, 8'h00, 32'h0);
      run_req(1'b1, 3'd4, 32'h10, 32'h5555_5555, 1'b0);
      expect_txn("st_f3_100", 1, 1'b1, 32'hDEAD_BEEF, 8'h00, 8'h00, 32'h0);
      run_req(1'b1, 3'd2, 32'h32, 32'h5555_5555, 1'b0);
      expect_txn("sw_mis", 1, 1'b1, 32'hDEAD_BEEF, 8'h00, 8'h00, 32'h0);

      run_req(1'b1, 3'd1, 32'h22, 32'h1234_CAFE, 1'b0);
      expect_txn("sh_hi", 3, 1'b0, 32'hDEAD_BEEF, 8'h02, 8'h04, 32'h20);
      check("sh_wdata", wr_word, 32'hCAFE_EE44);
      run_req(1'b0, 3'd0, 32'h20, 32'h0, 1'b0);
      expect_txn("lb_pos", 2, 1'b0, 32'h0000_0044, 8'h02, 8'h00, 32'h20);

      // Back-to-back with req held high, scored against ref_mem.
      e_rdata = 32'h0000_0044;
      acc0 = accept_count;
      for (int n = 0; n < 20; n++) begin
         we    = 1'($urandom_range(0, 1));
         f3    = pick_f3($urandom_range(0, 6));
         addr  = 32'h40 + 32'($urandom_range(0, 15));
         wdata = $urandom;
         idx   = int'(addr[31:2]);
         e_err = m_err(we, f3, addr[1:0]);
         e_ren = 8'h00;
         e_wen = 8'h00;
         e_addr = 32'h0;
         if (e_err) begin
            e_lat = 1;
         end else begin
            e_addr = {addr[31:2], 2'b00};
            if (!we) begin
               e_lat = 2;
               e_ren = 8'h02;
               e_rdata = m_load(ref_mem[idx], f3, addr[1:0]);
            end else if (f3 == 3'd2) begin
               e_lat = 2;
               e_wen = 8'h02;
               ref_mem[idx] = wdata;
            end else begin
               e_lat = 3;
               e_ren = 8'h02;
               e_wen = 8'h04;
               ref_mem[idx] = m_store(ref_mem[idx], wdata, f3, addr[1:0]);
            end
         end
         run_req(we, f3, addr, wdata, 1'b1);
         expect_txn($sformatf("b2b%0d", n), e_lat, e_err, e_rdata, e_ren, e_wen, e_addr);
      end
      bus.lsu_req = 1'b0;
      @(negedge clk);
      check_b("b2b_ready_end", bus.lsu_ready, 1'b1);
      check("b2b_accepts", accept_count - acc0, 32'd20);
      for (int i = 16; i < 20; i++) check($sformatf("b2b_mem%0d", i), mem[i], ref_mem[i]);

      // Reset asserted during RMW_RD of an SH to 0x52.
      wc0 = wr_count;
      @(negedge clk);
      bus.lsu_req    = 1'b1;
      bus.lsu_we     = 1'b1;
      bus.lsu_funct3 = 3'd1;
      bus.lsu_addr   = 32'h52;
      bus.lsu_wdata  = 32'h0000_BEEF;
      @(negedge clk);
      bus.lsu_req = 1'b0;
      check_b("rmw_rd_ren", bus.mem_ren, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check_b("rstmid_ren", bus.mem_ren, 1'b0);
      check_b("rstmid_wen", bus.mem_wen, 1'b0);
      check("rstmid_maddr", bus.mem_addr, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_b("rel_ready", bus.lsu_ready, 1'b1);
      check_b("rel_done", bus.lsu_done, 1'b0);
      check("rel_rdata", bus.lsu_rdata, 32'h0);
      check("rel_mem", mem[20], 32'h0102_0304);
      check("rel_wr_count", wr_count - wc0, 32'd0);
      repeat (3) @(negedge clk);
      check_b("ren_wen_exclusive", both_seen, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store controller that sits directly upstream of the data memory. It accepts one core memory request at a time through a req/ready handshake. It translates RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word-wide memory accesses: sub-word stores use read-modify-write, and loads are extracted and sign- or zero-extended. A done pulse returns the load data or an error flag to the core.

Parameters:
CPU_WIDTH, 32, data and address width; must match the `CPU_WIDTH` macro used by the data memory.
DATA_MEM_ADDR_WIDTH, 8, word-index width of the data memory; only mem_addr[DATA_MEM_ADDR_WIDTH+1:0] is significant downstream.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
lsu_req  in  1  core request valid.
lsu_ready  out  1  controller can accept; high only in IDLE.
lsu_we  in  1  1 = store, 0 = load.
lsu_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
lsu_addr  in  CPU_WIDTH  byte address.
lsu_wdata  in  CPU_WIDTH  store data, right-aligned.
lsu_done  out  1  one-cycle completion pulse.
lsu_err  out  1  valid with lsu_done; misaligned or illegal funct3.
lsu_rdata  out  CPU_WIDTH  extended load result, held until the next done.
mem_wen  out  1  to data memory write enable.
mem_ren  out  1  to data memory read enable.
mem_addr  out  CPU_WIDTH  word-aligned address; bits [1:0] are always 0.
mem_wdata  out  CPU_WIDTH  full write word.
mem_rdata  in  CPU_WIDTH  combinational read data from the memory.

Behaviour:
- Reset (async, rst_n=0): state IDLE; lsu_done=0, lsu_err=0, lsu_rdata=0; request registers are cleared. mem_wen, mem_ren and mem_addr=0 are decoded from the state, so they drop asynchronously. Reset mid-RMW aborts the operation with no write.
- Handshake: a request is accepted on the edge where lsu_req && lsu_ready; addr, funct3, we and wdata are registered at that edge. While busy, inputs are ignored and no request is queued.
- Checks at accept:
  - Illegal funct3: 011, 110 or 111, for loads and stores alike. Store funct3 must also be 000, 001 or 010.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Either case -> ERR path.
- States: IDLE, LOAD, ST_WR, RMW_RD, RMW_WR, RESP.
  - IDLE -> RESP on error, with err=1.
  - IDLE -> LOAD for a load.
  - IDLE -> ST_WR for SW.
  - IDLE -> RMW_RD for SB/SH.
  - LOAD: mem_ren=1. Capture the extracted mem_rdata into lsu_rdata. -> RESP.
  - ST_WR: mem_wen=1, mem_wdata=wdata. -> RESP.
  - RMW_RD: mem_ren=1. Latch mem_rdata into the merge register. -> RMW_WR.
  - RMW_WR: mem_wen=1. mem_wdata = merge word with the byte/half lane replaced by wdata[7:0]/[15:0] at lane addr[1:0]. -> RESP.
  - RESP: lsu_done=1 and lsu_err valid for exactly one cycle. -> IDLE, ready again the next cycle.
- mem_ren and mem_wen are never high together. Outside the states listed above both are 0.
- Latency, counted from the accept edge at T, gives lsu_done high in cycle:
  - error: T+1
  - load or SW: T+2
  - SB/SH: T+3
- Back-to-back: a new request can be accepted on the cycle after RESP at the earliest.
- Extraction (little-endian):
  - byte = word[8*addr[1:0] +: 8]
  - half = word[16*addr[1] +: 16]
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Error or store completion: lsu_rdata is unchanged.
- mem_addr = {addr[CPU_WIDTH-1:2], 2'b00}. Address wrap beyond the memory depth is the memory's concern; there is no range check.

Decomposition:
- Shared package/include:
  - funct3 encodings (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU)
  - state encodings
  - `CPU_WIDTH` and `DATA_MEM_ADDR_WIDTH`
- One natural sub-module, lsu_align, which is purely combinational:
  - load extract/extend (word, addr[1:0], funct3 -> rdata)
  - store merge (old word, wdata, addr[1:0], funct3 -> new word)
- The FSM and registers stay in lsu_mem_ctrl.

Test Plan:
- Memory word 0x10 preloaded with 0x8899AABB. LB addr 0x11 -> lsu_rdata=0xFFFFFFAA, done at T+2, err=0. LBU addr 0x13 -> 0x00000088.
- LH addr 0x12 on 0x8899AABB -> 0xFFFF8899. LHU addr 0x10 -> 0x0000AABB. mem_addr=0x10 in both.
- SB addr 0x21, wdata 0x000000EE, over 0x11223344:
  - mem_ren in T+1, then mem_wen with mem_wdata=0x1122EE44 in T+2, done at T+3.
  - A following LW returns 0x1122EE44.
- SW addr 0x30, wdata 0xDEADBEEF -> a single mem_wen cycle, done at T+2. LH addr 0x31 -> err=1 at T+1 with no mem_ren/mem_wen. funct3=011 -> err=1 at T+1.
- lsu_req held high continuously: ready low while busy, new accept on the cycle after done, and no request is lost or duplicated over 20 random transactions checked against a reference memory model.
- rst_n asserted during RMW_RD of an SH -> mem_ren drops immediately, no mem_wen ever occurs, the target word is unchanged, and after release ready=1 and done=0.
